// File: rtl/mtx_hop_frame_scheduler.sv
// Frame-level sequencer for the multi-tone/pilot hop generator: start/stop, guard gaps, progress and drop reporting.
// Optional hop_ready alignment checking is enabled by defining MTX_HOP_SYNC_CHECK_EN.
module mtx_hop_frame_scheduler #(
    parameter int NSIG_WIDTH   = 24,
    parameter int NSYMB_WIDTH  = 16,
    parameter int NFRAME_WIDTH = 16,
    parameter int GUARD_WIDTH  = 16,
    parameter int NSIG         = 65536,
    parameter int NSYMB        = 512,
    parameter int GUARD_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [NFRAME_WIDTH-1:0] cmd_nframes,
    input  logic                    stop,
    output logic                    gen_srst,
    output logic                    phase_tvalid,
    output logic                    phase_tlast,
    input  logic                    phase_tready,
    input  logic                    hop_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    done,
    output logic [NFRAME_WIDTH-1:0] frame_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    sync_err
);

    typedef enum logic [2:0] {IDLE, SRST, RUN, GUARD, DONE} state_t;

    localparam logic [NSIG_WIDTH-1:0]  SAMP_LAST  = NSIG_WIDTH'(NSIG);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST  = NSYMB_WIDTH'(NSYMB);
    localparam logic [GUARD_WIDTH-1:0] GUARD_LAST = GUARD_WIDTH'(GUARD_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [NSIG_WIDTH-1:0]   samp;
    logic [NSYMB_WIDTH-1:0]  symb;
    logic [GUARD_WIDTH-1:0]  guard_cnt;
    logic [NFRAME_WIDTH-1:0] nframes_q;
    logic                    stop_pend;

    logic                    samp_last;
    logic                    frame_end;
    logic                    stop_now;
    logic                    last_frame;
    logic [NFRAME_WIDTH-1:0] frame_cnt_inc;

    assign samp_last     = (samp == SAMP_LAST);
    assign frame_end     = samp_last && (symb == SYMB_LAST);
    assign stop_now      = stop_pend || stop;
    assign frame_cnt_inc = frame_cnt + 1'b1;
    assign last_frame    = (nframes_q != '0) && (frame_cnt_inc == nframes_q);

    assign cmd_ready    = (state == IDLE);
    assign phase_tvalid = (state == RUN);
    assign phase_tlast  = (state == RUN) && samp_last;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cmd_valid) state_next = SRST;
            SRST:  state_next = RUN;
            RUN: begin
                if (frame_end) begin
                    if (stop_now || last_frame)
                        state_next = DONE;
                    else if (GUARD_CYCLES > 0)
                        state_next = GUARD;
                end else if (samp_last && stop_now) begin
                    state_next = DONE;
                end
            end
            GUARD: begin
                if (stop)
                    state_next = DONE;
                else if (guard_cnt == GUARD_LAST)
                    state_next = RUN;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Sample/symbol position free-runs in RUN, mirroring the generator which never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gen_srst   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            samp       <= NSIG_WIDTH'(1);
            symb       <= NSYMB_WIDTH'(1);
            guard_cnt  <= '0;
            nframes_q  <= '0;
            stop_pend  <= 1'b0;
        end else begin
            state      <= state_next;
            gen_srst   <= (state_next != RUN);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
            frame_done <= (state == RUN) && frame_end;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        nframes_q <= cmd_nframes;
                        frame_cnt <= '0;
                        drop_cnt  <= '0;
                        stop_pend <= 1'b0;
                    end
                end
                SRST: begin
                    samp <= NSIG_WIDTH'(1);
                    symb <= NSYMB_WIDTH'(1);
                end
                RUN: begin
                    guard_cnt <= '0;
                    stop_pend <= stop_now;
                    if (!phase_tready && (drop_cnt != 16'hFFFF))
                        drop_cnt <= drop_cnt + 16'd1;
                    if (samp_last) begin
                        samp <= NSIG_WIDTH'(1);
                        if (symb == SYMB_LAST)
                            symb <= NSYMB_WIDTH'(1);
                        else
                            symb <= symb + 1'b1;
                    end else begin
                        samp <= samp + 1'b1;
                    end
                    if (frame_end)
                        frame_cnt <= frame_cnt_inc;
                end
                GUARD: begin
                    guard_cnt <= guard_cnt + 1'b1;
                    samp      <= NSIG_WIDTH'(1);
                    symb      <= NSYMB_WIDTH'(1);
                end
                DONE: begin
                    stop_pend <= 1'b0;
                end
                default: begin
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

`ifdef MTX_HOP_SYNC_CHECK_EN
    // Sticky: any RUN cycle where the generator's end-of-frame flag disagrees with our position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_err <= 1'b0;
        else if ((state == IDLE) && cmd_valid)
            sync_err <= 1'b0;
        else if ((state == RUN) && (hop_ready != frame_end))
            sync_err <= 1'b1;
    end
`else
    logic unused_hop_ready;
    assign unused_hop_ready = hop_ready;
    assign sync_err         = 1'b0;
`endif

endmodule

// File: doc/mtx_hop_frame_scheduler.md
Name: mtx_hop_frame_scheduler

Overview:
- Sequences the multi-tone/pilot hop signal generator (DDS pair plus hop counters) on a frame basis.
- Accepts start commands and drives the generator's synchronous reset, phase_tvalid and phase_tlast.
- Tracks sample, symbol and frame position in lock-step with the generator's free-running counters.
- Inserts guard gaps between frames, stops cleanly at a symbol boundary, and reports progress, dropped samples and alignment errors.

Parameters:
- NSIG_WIDTH, 24, width of the sample-in-symbol counter.
- NSYMB_WIDTH, 16, width of the symbol-in-frame counter.
- NFRAME_WIDTH, 16, width of the frame count and command field.
- GUARD_WIDTH, 16, width of the guard counter.
- NSIG, 65536, samples per symbol; must match the generator.
- NSYMB, 512, symbols per frame; must match the generator.
- GUARD_CYCLES, 64, idle cycles between consecutive frames; 0 means back-to-back frames.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  start command valid
- cmd_ready  out  1  scheduler can accept a command
- cmd_nframes  in  NFRAME_WIDTH  frames to send; 0 means continuous until stop
- stop  in  1  single-cycle stop request
- gen_srst  out  1  synchronous reset to the generator
- phase_tvalid  out  1  to the generator's phase input
- phase_tlast  out  1  last sample of a symbol
- phase_tready  in  1  from the generator
- hop_ready  in  1  generator's end-of-frame flag
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle pulse at end of each frame
- done  out  1  one-cycle pulse when a run ends
- frame_cnt  out  NFRAME_WIDTH  frames completed in the current run
- drop_cnt  out  16  saturating count of RUN cycles with phase_tready=0
- sync_err  out  1  sticky hop_ready misalignment flag

Behaviour:
- Reset (async) values: state=IDLE; cmd_ready=1; gen_srst=1; phase_tvalid=0; phase_tlast=0; busy=0; frame_done=0; done=0; frame_cnt=0; drop_cnt=0; sync_err=0; samp=1; symb=1.
- All outputs are registered except cmd_ready, phase_tvalid and phase_tlast, which decode directly from state and counters.
- States: IDLE, SRST, RUN, GUARD, DONE.
- IDLE:
  - cmd_ready=1 and gen_srst=1.
  - On cmd_valid: latch cmd_nframes, clear frame_cnt, drop_cnt and sync_err, then go to SRST.
  - stop is ignored in IDLE.
- SRST:
  - gen_srst=1 for exactly one cycle, samp=1, symb=1, then go to RUN.
  - Latency: command accepted at cycle T gives first phase_tvalid at T+2.
- RUN:
  - gen_srst=0 and phase_tvalid=1.
  - samp increments every cycle, because the generator free-runs and does not stall on handshake.
  - At samp==NSIG: phase_tlast=1, samp goes to 1, and symb increments. When symb==NSYMB, symb goes to 1; this is the end-of-frame cycle.
  - drop_cnt increments on each RUN cycle with phase_tready=0, saturating at 16'hFFFF.
- End-of-frame cycle:
  - frame_done pulses on the next cycle and frame_cnt increments.
  - If a stop is pending, or nframes!=0 and frame_cnt+1==nframes: go to DONE.
  - Else if GUARD_CYCLES>0: go to GUARD.
  - Else: stay in RUN; the generator wraps by itself.
- stop during RUN sets a pending flag. The run ends at the next cycle with samp==NSIG (symbol boundary), going to DONE; that partial frame does not count.
- GUARD:
  - gen_srst=1 (holds the generator at its start state) and phase_tvalid=0.
  - Runs for GUARD_CYCLES cycles, then goes to RUN with samp=1, symb=1.
  - stop during GUARD goes to DONE immediately.
- DONE:
  - gen_srst=1 and done pulses for one cycle, then go to IDLE.
  - frame_cnt holds until the next command.
- Simultaneous events:
  - stop in the same cycle as end-of-frame goes to DONE, counting that frame.
  - stop in the same cycle as cmd accept is ignored.
  - cmd_valid while busy is not accepted (cmd_ready=0).
- Counter widths:
  - frame_cnt wraps modulo 2^NFRAME_WIDTH in continuous mode.
  - The samp and symb comparisons are exact equality.

Optional Feature:
- Macro: MTX_HOP_SYNC_CHECK_EN.
- When defined: each RUN cycle compares hop_ready with the internal end-of-frame condition (samp==NSIG && symb==NSYMB). Any mismatch sets sync_err, which clears only on reset or a new command.
- When not defined: hop_ready is unused and sync_err is tied to 0.

Test Plan (NSIG=8, NSYMB=4, GUARD_CYCLES=3, phase_tready=1 unless noted):
- cmd_nframes=2 at T:
  - gen_srst high at T+1; phase_tvalid from T+2 to T+33.
  - 3 guard cycles with gen_srst=1.
  - 32 more valid cycles, with phase_tlast on every 8th cycle.
  - frame_done twice, done once, frame_cnt=2.
- cmd_nframes=0 with stop asserted on sample 3 of symbol 2 in frame 1:
  - Run ends after sample 8 of that symbol.
  - done pulses and frame_cnt=0.
- GUARD_CYCLES=0, cmd_nframes=3: 96 consecutive valid cycles, no gen_srst between frames, frame_cnt=3.
- phase_tready held low for 5 RUN cycles: drop_cnt=5; sample timing unchanged.
- With MTX_HOP_SYNC_CHECK_EN defined, hop_ready forced one cycle early: sync_err=1 and it stays set until the next cmd.
- Async reset asserted mid-RUN:
  - All outputs return to reset values immediately.
  - After release, cmd_ready=1 in IDLE.
